// File: rtl/riscv_pipe_skid_stage.sv
// riscv_pipe_skid_stage: two-entry elastic valid/ready stage with registered ready and synchronous flush
module riscv_pipe_skid_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NWORD = 6,
  parameter logic [XLEN-1:0] DATA_INIT = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [NWORD*XLEN-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [NWORD*XLEN-1:0] o_data,
  output logic [1:0]            o_count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nxt;
  logic [NWORD*XLEN-1:0] main_q, skid_q;
  logic in_fire, out_fire, ld_main_in, ld_main_skid, ld_skid;
  assign o_valid  = state != EMPTY;
  assign o_ready  = state != FULL;
  assign o_count  = {state == FULL, state == ONE};
  assign o_data   = main_q;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;
  // next state and register load enables; flush overrides every transition and write
  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (i_flush) state_nxt = EMPTY;
    else case (state)
      EMPTY: begin
        ld_main_in = in_fire;
        state_nxt  = in_fire ? ONE : EMPTY;
      end
      ONE: begin
        ld_main_in = in_fire & out_fire;
        ld_skid    = in_fire & ~out_fire;
        state_nxt  = (in_fire & ~out_fire) ? FULL : (~in_fire & out_fire) ? EMPTY : ONE;
      end
      FULL: begin
        ld_main_skid = out_fire;
        state_nxt    = out_fire ? ONE : FULL;
      end
      default: state_nxt = EMPTY;
    endcase
  end
  // state register
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) state <= EMPTY;
    else state <= state_nxt;
  // main and skid data registers, written only on accepted or promoted bundles
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      main_q <= {NWORD{DATA_INIT}};
      skid_q <= {NWORD{DATA_INIT}};
    end else begin
      if (ld_main_in) main_q <= i_data;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid) skid_q <= i_data;
    end
endmodule

// File: tb/tb_riscv_pipe_skid_stage.sv
// tb_riscv_pipe_skid_stage: directed and randomized checks against a queue-based model
module tb_riscv_pipe_skid_stage;
  localparam int W = 192;
  logic clk, rstn, flush, valid, ready_in, o_ready, o_valid;
  logic [W-1:0] din, o_data;
  logic [1:0] o_count;
  logic [W-1:0] q[$];
  int checks, failures;

  riscv_pipe_skid_stage dut (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
    .i_data(din), .o_valid(o_valid), .i_ready(ready_in), .o_data(o_data), .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [31:0] w0);
    mk = {$urandom, $urandom, $urandom, $urandom, $urandom, w0};
  endfunction

  task automatic tick();
    logic in_f, out_f;
    in_f  = valid && q.size() < 2;
    out_f = q.size() > 0 && ready_in;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(din);
    end
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; valid = 1'b0; ready_in = 1'b0; din = '0;
    #2;
    checks++;
    if ({o_valid, o_ready, o_count} !== 4'b0100 || o_data !== '0) begin
      failures++;
      $display("FAIL reset_initial: valid=%b ready=%b count=%0d data=%h required 0 1 0 0", o_valid, o_ready, o_count, o_data);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    valid = 1'b1;
    din = mk(32'h77); tick();
    din = mk(32'h78); tick();
    checks++;
    if (o_count !== 2'd2 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_prefill: count=%0d ready=%b required 2 0", o_count, o_ready);
    end
    #3 rstn = 1'b0; valid = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_ready, o_count} !== 4'b0100 || o_data !== '0) begin
      failures++;
      $display("FAIL reset_async: valid=%b ready=%b count=%0d data=%h required 0 1 0 0", o_valid, o_ready, o_count, o_data);
    end
    q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_streaming();
    ready_in = 1'b1; valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      din = mk(32'(k)); tick();
      checks++;
      if (o_data[31:0] !== 32'(k) || o_valid !== 1'b1 || o_count !== 2'd1 || o_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_%0d: word0=%0d valid=%b count=%0d ready=%b required %0d 1 1 1", k, o_data[31:0], o_valid, o_count, o_ready, k);
      end
    end
    valid = 1'b0; tick();
    checks++;
    if (o_valid !== 1'b0 || o_count !== 2'd0) begin
      failures++;
      $display("FAIL stream_drain: valid=%b count=%0d required 0 0", o_valid, o_count);
    end
  endtask

  task automatic test_backpressure();
    ready_in = 1'b0; valid = 1'b1;
    din = mk(32'hA); tick();
    din = mk(32'hB); tick();
    checks++;
    if (o_count !== 2'd2 || o_ready !== 1'b0 || o_data[31:0] !== 32'hA) begin
      failures++;
      $display("FAIL skid_full: count=%0d ready=%b word0=%h required 2 0 a", o_count, o_ready, o_data[31:0]);
    end
    valid = 1'b0; ready_in = 1'b1; tick();
    checks++;
    if (o_data[31:0] !== 32'hB || o_ready !== 1'b1 || o_count !== 2'd1) begin
      failures++;
      $display("FAIL skid_release1: word0=%h ready=%b count=%0d required b 1 1", o_data[31:0], o_ready, o_count);
    end
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_count !== 2'd0) begin
      failures++;
      $display("FAIL skid_release2: valid=%b count=%0d required 0 0", o_valid, o_count);
    end
  endtask

  task automatic test_simultaneous();
    ready_in = 1'b0; valid = 1'b1; din = mk(32'h11); tick();
    ready_in = 1'b1; din = mk(32'h22); tick();
    checks++;
    if (o_data[31:0] !== 32'h22 || o_count !== 2'd1 || o_data !== q[0]) begin
      failures++;
      $display("FAIL simul_fire: word0=%h count=%0d required 22 1", o_data[31:0], o_count);
    end
    valid = 1'b0; tick();
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_drain: valid=%b required 0", o_valid);
    end
  endtask

  task automatic test_flush();
    ready_in = 1'b0; valid = 1'b1;
    din = mk(32'h33); tick();
    din = mk(32'h44); tick();
    flush = 1'b1; din = mk(32'h55); tick();
    flush = 1'b0; valid = 1'b0;
    checks++;
    if ({o_valid, o_ready, o_count} !== 4'b0100) begin
      failures++;
      $display("FAIL flush_full: valid=%b ready=%b count=%0d required 0 1 0", o_valid, o_ready, o_count);
    end
    valid = 1'b1; din = mk(32'h66); tick();
    valid = 1'b0;
    checks++;
    if (o_data[31:0] !== 32'h66 || o_count !== 2'd1) begin
      failures++;
      $display("FAIL flush_next: word0=%h count=%0d required 66 1", o_data[31:0], o_count);
    end
    ready_in = 1'b1; tick();
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_drain: valid=%b required 0", o_valid);
    end
  endtask

  task automatic test_soak();
    logic hold;
    logic [W-1:0] prev;
    for (int c = 0; c < 10000; c++) begin
      valid    = ($urandom_range(0, 9) < 7);
      ready_in = ($urandom_range(0, 9) < 5);
      flush    = ($urandom_range(0, 31) == 0);
      din      = mk($urandom);
      hold     = o_valid && !ready_in;
      prev     = o_data;
      tick();
      checks++;
      if ({o_valid, o_ready, o_count} !== {q.size() > 0, q.size() < 2, 2'(q.size())}) begin
        failures++;
        $display("FAIL soak_ctrl@%0d: valid=%b ready=%b count=%0d required count %0d", c, o_valid, o_ready, o_count, q.size());
      end
      if (q.size() > 0) begin
        checks++;
        if (o_data !== q[0]) begin
          failures++;
          $display("FAIL soak_data@%0d: data=%h required %h", c, o_data, q[0]);
        end
      end
      if (hold) begin
        checks++;
        if (o_data !== prev) begin
          failures++;
          $display("FAIL soak_stable@%0d: data=%h required %h", c, o_data, prev);
        end
      end
    end
    flush = 1'b0; valid = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
